// File: rtl/arb_mux.sv
// N-way arbitrated selector with per-channel valid/ready handshake and a
// one-entry registered output stage (fixed-priority or round-robin grant).
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  base;
  logic             found;
  logic             any_req;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  // Rotating search done as two linear passes: channels at or above the
  // start point first, then the wrapped-around remainder.
  always_comb begin
    grant = '0;
    found = 1'b0;
    base  = mode ? rr_ptr_q : '0;
    for (int i = 0; i < N; i++) begin
      if (!found && in_valid[i] && (SELW'(i) >= base)) begin
        found = 1'b1;
        grant = SELW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && in_valid[i]) begin
        found = 1'b1;
        grant = SELW'(i);
      end
    end
  end

  assign any_req = |in_valid;
  assign load_en = !out_valid_q || out_ready;
  assign xfer    = !rst && load_en && any_req;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (grant == SELW'(i));
      if (grant == SELW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = grant;
      // Explicit wrap keeps the pointer legal when N is not a power of two.
      rr_ptr_d    = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-way datapath selector that generalises the combinational two/four/eight/sixteen-way select muxes.
- Adds a per-channel valid/ready handshake, fixed-priority or round-robin arbitration, and a one-entry registered output stage.
- Sits between multiple requesters (e.g. fetch, load/store, debug) and a shared single-ported consumer such as a memory port or writeback bus.
- Selection is decided by the block from the channel valids, not supplied externally.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 4, number of input channels; legal range 2..16, need not be a power of two.
- SELW, $clog2(N), width of the channel index and of out_sel; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- in_valid  input  N  bit i high means channel i presents data.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  bit i high means channel i's data is taken this cycle; at most one bit is high.
- out_valid  output  1  the output register holds data.
- out_data  output  WIDTH  the registered data.
- out_sel  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  the consumer takes out_data this cycle when out_valid is also high.

Behaviour:
- Reset: out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is all zeros during the reset cycle.
- Reset mid-operation: any held entry is discarded without a handshake; no in_ready pulse occurs in that cycle.
- load_en = !out_valid || out_ready. The output register accepts a new entry when it is empty or being drained in the same cycle, giving full throughput of one transfer per cycle.
- Grant computation (combinational):
  - mode=0: grant = lowest i with in_valid[i]=1.
  - mode=1: grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
  - any_req = |in_valid.
- in_ready[i] = load_en && any_req && (grant==i). It is a function of in_valid, mode, rr_ptr, out_valid and out_ready only; it never depends on in_data.
- Transfer on channel i when in_valid[i] && in_ready[i]. On the next edge: out_data <= channel i data, out_sel <= i, out_valid <= 1.
- Drain with no new load (out_valid && out_ready && !any_req): out_valid <= 0. out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): out_valid, out_data and out_sel hold, and in_ready is all zeros. out_data must not change while out_valid=1 and out_ready=0.
- Latency: input handshake in cycle t gives out_valid=1 with that data in cycle t+1.
- rr_ptr update:
  - Only on an input transfer: rr_ptr <= (grant==N-1) ? 0 : grant+1. Explicit wrap; no modulo on non-power-of-two N.
  - Updated in both modes, so a switch to mode=1 resumes rotation fairly.
  - No transfer: rr_ptr holds.
- Mode change takes effect on the same cycle's grant, because mode is used combinationally; there is no pipeline flush.
- Simultaneous drain and load: the new entry replaces the old with no bubble, and out_valid stays 1.
- Inputs must hold in_valid and in_data stable until their handshake. The block does not check this.
- No X on outputs after reset regardless of in_data content.

Test Plan:
- Reset, then N=4, mode=0, in_valid=4'b1010, out_ready=1 -> in_ready=4'b0010. Next cycle out_valid=1, out_sel=1, out_data=ch1 data; ch1 stays granted every cycle while its valid is high.
- mode=1, all four valids held high, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; one transfer per cycle with no bubbles.
- Stall: load ch2=32'hDEADBEEF, then out_ready=0 for 3 cycles with all valids high -> out_data holds 32'hDEADBEEF, in_ready=0 throughout. Releasing out_ready gives the next grant in the same cycle.
- N=3 parameter build, mode=1, ch2 only valid, then all valid -> after the ch2 grant rr_ptr wraps to 0; the next grants are 0,1,2.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_sel=0, out_data=0, in_ready=0. After reset, round-robin restarts at ch0.
- Empty drain: one transfer on ch3, then in_valid=0 with out_ready=1 -> out_valid falls after one cycle; out_sel stays 3.
